wb_stage: RTL and testbench

Write-back stage of the 5-stage MIPS pipeline. It consumes the MEM/WB results: control bus, destination register, ALU result and raw data-memory word. It aligns and extends load data, selects the write-back value and drives the register-file write port. A two-entry buffer with a valid/ready handshake lets the stage absorb cycles when the debug unit owns the register-file port. It also exports a forwarding path to EX and a retired-instruction counter.

---
 rtl/wb_stage_pkg.sv | 24 ++
 rtl/wb_stage_load_align.sv | 48 ++++
 rtl/wb_stage.sv | 141 ++++++++++++++
 tb/tb_wb_stage.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared write-back definitions: control-bus bit positions and load-size encodings.
// The memory and decode stages import the same package so the encodings stay in one place.
package wb_stage_pkg;

    localparam int WB_REG_WRITE  = 0;
    localparam int WB_MEM_TO_REG = 1;

    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;

    // Both word encodings (10 and 11) must sit on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic w_mis;
        w_mis = 1'b0;
        if (size == LD_HALF) begin
            w_mis = lsb[0];
        end else if (size[1]) begin
            w_mis = (lsb != 2'b00);
        end
        return w_mis;
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load alignment: picks the byte/half lane addressed by addr_lsb
// and sign- or zero-extends it; misaligned accesses still use the forced lane.
module load_align
    import wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [1:0]            ld_size,
    input  logic                  ld_unsigned,
    input  logic [1:0]            addr_lsb,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_byte_fill;
    logic        w_half_fill;

    always_comb begin
        w_byte = mem_data_in[7:0];
        case (addr_lsb)
            2'd0:    w_byte = mem_data_in[7:0];
            2'd1:    w_byte = mem_data_in[15:8];
            2'd2:    w_byte = mem_data_in[23:16];
            default: w_byte = mem_data_in[31:24];
        endcase
    end

    // A half load only looks at addr_lsb[1]; a set addr_lsb[0] is flagged, not honoured.
    assign w_half = addr_lsb[1] ? mem_data_in[31:16] : mem_data_in[15:0];

    assign w_byte_fill = ~ld_unsigned & w_byte[7];
    assign w_half_fill = ~ld_unsigned & w_half[15];

    always_comb begin
        data = mem_data_in;
        case (ld_size)
            LD_BYTE: data = {{(DATA_WIDTH-8){w_byte_fill}}, w_byte};
            LD_HALF: data = {{(DATA_WIDTH-16){w_half_fill}}, w_half};
            default: data = mem_data_in;
        endcase
    end

    assign misaligned = is_misaligned(ld_size, addr_lsb);

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: two-entry head/skid buffer in front of the register-file
// write port, plus EX forwarding, misalignment pulse and a retired-entry counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_ADDR_BITS = 5,
    parameter int WB_BUS_WIDTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WB_BUS_WIDTH-1:0]  wb_bus_in,
    input  logic [REG_ADDR_BITS-1:0] reg_w_addr_in,
    input  logic [DATA_WIDTH-1:0]    alu_data_in,
    input  logic [DATA_WIDTH-1:0]    mem_data_in,
    input  logic [1:0]               ld_size,
    input  logic                     ld_unsigned,
    input  logic [1:0]               addr_lsb,
    input  logic                     rf_grant,
    output logic                     rf_we,
    output logic [REG_ADDR_BITS-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]    rf_wdata,
    output logic                     fwd_valid,
    output logic [REG_ADDR_BITS-1:0] fwd_addr,
    output logic [DATA_WIDTH-1:0]    fwd_data,
    output logic                     align_err,
    output logic [31:0]              retired_count
);

    typedef struct packed {
        logic                     valid;
        logic                     reg_write;
        logic [REG_ADDR_BITS-1:0] waddr;
        logic [DATA_WIDTH-1:0]    wdata;
    } entry_t;

    entry_t                r_head;
    entry_t                r_skid;
    logic                  r_align_err;
    logic [31:0]           r_retired_count;

    entry_t                w_new;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_misaligned;
    logic                  w_mem_to_reg;
    logic                  w_accept;
    logic                  w_head_needs_write;
    logic                  w_retire;

    load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .mem_data_in (mem_data_in),
        .ld_size     (ld_size),
        .ld_unsigned (ld_unsigned),
        .addr_lsb    (addr_lsb),
        .data        (w_load_data),
        .misaligned  (w_misaligned)
    );

    // Handshake: a transfer happens on a rising edge where in_valid && in_ready.
    // in_ready depends only on registered state (skid empty); upstream holds its
    // data while in_ready is low, and in_valid alone never changes our state.
    assign in_ready = !r_skid.valid;
    assign w_accept = in_valid && in_ready;

    assign w_mem_to_reg    = wb_bus_in[WB_MEM_TO_REG];
    assign w_new.valid     = 1'b1;
    assign w_new.reg_write = wb_bus_in[WB_REG_WRITE];
    assign w_new.waddr     = reg_w_addr_in;
    assign w_new.wdata     = w_mem_to_reg ? w_load_data : alu_data_in;

    // Entries that write nothing (no reg_write, or $zero) retire without waiting for grant.
    assign w_head_needs_write = r_head.reg_write && (r_head.waddr != '0);
    assign w_retire           = r_head.valid && (rf_grant || !w_head_needs_write);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head          <= '0;
            r_skid          <= '0;
            r_align_err     <= 1'b0;
            r_retired_count <= 32'd0;
        end else begin
            r_align_err <= w_accept && w_mem_to_reg && w_misaligned;
            if (w_retire) begin
                r_retired_count <= r_retired_count + 32'd1;
            end
            if (w_accept) begin
                if (!r_head.valid || w_retire) begin
                    if (!r_skid.valid) begin
                        r_head <= w_new;
                    end else begin
                        r_head <= r_skid;
                        r_skid <= w_new;
                    end
                end else begin
                    r_skid <= w_new;
                end
            end else if (w_retire) begin
                if (r_skid.valid) begin
                    r_head <= r_skid;
                    r_skid <= '0;
                end else begin
                    r_head <= '0;
                end
            end
        end
    end

    always_comb begin
        rf_we    = r_head.valid && w_head_needs_write && rf_grant;
        rf_waddr = '0;
        rf_wdata = '0;
        if (r_head.valid) begin
            rf_waddr = r_head.waddr;
            rf_wdata = r_head.wdata;
        end
    end

    // The skid entry is younger than the head, so it wins when both target a register.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_addr  = '0;
        fwd_data  = '0;
        if (r_skid.valid && r_skid.reg_write && (r_skid.waddr != '0)) begin
            fwd_valid = 1'b1;
            fwd_addr  = r_skid.waddr;
            fwd_data  = r_skid.wdata;
        end else if (r_head.valid && w_head_needs_write) begin
            fwd_valid = 1'b1;
            fwd_addr  = r_head.waddr;
            fwd_data  = r_head.wdata;
        end
    end

    assign align_err     = r_align_err;
    assign retired_count = r_retired_count;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus random traffic against
// an in-order queue model of pending write-back entries.
module tb_wb_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int BW = 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] wb_bus_in;
  logic [AW-1:0] reg_w_addr_in;
  logic [DW-1:0] alu_data_in;
  logic [DW-1:0] mem_data_in;
  logic [1:0]    ld_size;
  logic          ld_unsigned;
  logic [1:0]    addr_lsb;
  logic          rf_grant;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;
  logic          align_err;
  logic [31:0]   retired_count;

  wb_stage #(
    .DATA_WIDTH    (DW),
    .REG_ADDR_BITS (AW),
    .WB_BUS_WIDTH  (BW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .wb_bus_in     (wb_bus_in),
    .reg_w_addr_in (reg_w_addr_in),
    .alu_data_in   (alu_data_in),
    .mem_data_in   (mem_data_in),
    .ld_size       (ld_size),
    .ld_unsigned   (ld_unsigned),
    .addr_lsb      (addr_lsb),
    .rf_grant      (rf_grant),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .fwd_valid     (fwd_valid),
    .fwd_addr      (fwd_addr),
    .fwd_data      (fwd_data),
    .align_err     (align_err),
    .retired_count (retired_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // Each pending entry, oldest first: {reg_write, waddr, wdata}.
  logic [37:0] exp_q[$];
  logic [31:0] exp_count;
  logic        exp_align;
  int          n_checks;
  int          n_fail;
  logic [31:0] base_count;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_value(input logic m2r, input logic [31:0] alu,
                                            input logic [31:0] mem, input logic [1:0] sz,
                                            input logic uns, input logic [1:0] lsb);
    logic [31:0] v;
    int          sh;
    if (!m2r) return alu;
    if (sz == 2'b00) begin
      sh = 8 * int'(lsb);
      v  = (mem >> sh) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      sh = (int'(lsb) >= 2) ? 16 : 0;
      v  = (mem >> sh) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = mem;
    end
    return v;
  endfunction

  function automatic logic ref_misaligned(input logic [1:0] sz, input logic [1:0] lsb);
    if (sz == 2'b01) return (int'(lsb) % 2) == 1;
    if (sz == 2'b00) return 1'b0;
    return lsb != 2'b00;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [1:0] wb, input logic [4:0] a,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [1:0] sz,
                       input logic u, input logic [1:0] lsb, input logic g);
    in_valid      = v;
    wb_bus_in     = wb;
    reg_w_addr_in = a;
    alu_data_in   = alu;
    mem_data_in   = mem;
    ld_size       = sz;
    ld_unsigned   = u;
    addr_lsb      = lsb;
    rf_grant      = g;
  endtask

  task automatic drive_idle(input logic g);
    drive(1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 2'b10, 1'b0, 2'd0, g);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_count = 32'd0;
    exp_align = 1'b0;
  endtask

  // Compare every output against the queue model, then apply this cycle's edge.
  task automatic compare_model();
    logic [37:0] h;
    logic        has;
    logic        e_fv;
    logic [4:0]  e_fa;
    logic [31:0] e_fd;
    logic        acc;
    logic        ret;
    if (rst) model_reset();
    has = exp_q.size() > 0;
    h   = has ? exp_q[0] : 38'd0;
    check_eq("rf_we", rf_we, has && h[37] && (h[36:32] != 5'd0) && rf_grant);
    check_eq("rf_waddr", rf_waddr, has ? h[36:32] : 5'd0);
    check_eq("rf_wdata", rf_wdata, has ? h[31:0] : 32'd0);
    check_eq("in_ready", in_ready, exp_q.size() < 2);
    e_fv = 1'b0;
    e_fa = 5'd0;
    e_fd = 32'd0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (!e_fv && exp_q[i][37] && (exp_q[i][36:32] != 5'd0)) begin
        e_fv = 1'b1;
        e_fa = exp_q[i][36:32];
        e_fd = exp_q[i][31:0];
      end
    end
    check_eq("fwd_valid", fwd_valid, e_fv);
    check_eq("fwd_addr", fwd_addr, e_fa);
    check_eq("fwd_data", fwd_data, e_fd);
    check_eq("align_err", align_err, exp_align);
    check_eq("retired_count", retired_count, exp_count);
    if (!rst) begin
      acc = in_valid && (exp_q.size() < 2);
      ret = has && (rf_grant || !h[37] || (h[36:32] == 5'd0));
      exp_align = acc && wb_bus_in[1] && ref_misaligned(ld_size, addr_lsb);
      if (ret) begin
        void'(exp_q.pop_front());
        exp_count = exp_count + 32'd1;
      end
      if (acc) begin
        exp_q.push_back({wb_bus_in[0], reg_w_addr_in,
                         ref_value(wb_bus_in[1], alu_data_in, mem_data_in,
                                   ld_size, ld_unsigned, addr_lsb)});
      end
    end
  endtask

  task automatic step();
    settle();
    compare_model();
    advance();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    rst = 1'b1;
    drive_idle(1'b0);
    step();
    rst = 1'b0;
    drive_idle(1'b1);
    step();

    // Byte load, lane 2, signed -> all ones.
    drive(1'b1, 2'b11, 5'd3, 32'd0, 32'h80FF_7F01, 2'b00, 1'b0, 2'd2, 1'b1);
    step();
    drive_idle(1'b1);
    settle();
    check_eq("byte_signed_we", rf_we, 1'b1);
    check_eq("byte_signed_data", rf_wdata, 32'hFFFF_FFFF);
    compare_model();
    advance();
    // Byte load, lane 3, unsigned.
    drive(1'b1, 2'b11, 5'd4, 32'd0, 32'h80FF_7F01, 2'b00, 1'b1, 2'd3, 1'b1);
    step();
    drive_idle(1'b1);
    settle();
    check_eq("byte_unsigned_data", rf_wdata, 32'h0000_0080);
    compare_model();
    advance();

    // Stall and skid.
    base_count = exp_count;
    drive(1'b1, 2'b01, 5'd5, 32'h11, 32'd0, 2'b10, 1'b0, 2'd0, 1'b0);
    step();
    drive(1'b1, 2'b01, 5'd6, 32'h22, 32'd0, 2'b10, 1'b0, 2'd0, 1'b0);
    step();
    drive(1'b1, 2'b01, 5'd9, 32'h99, 32'd0, 2'b10, 1'b0, 2'd0, 1'b0);
    settle();
    check_eq("stall_in_ready", in_ready, 1'b0);
    check_eq("stall_no_we", rf_we, 1'b0);
    compare_model();
    advance();
    rf_grant = 1'b1;
    settle();
    check_eq("skid_first_addr", rf_waddr, 32'd5);
    check_eq("skid_first_data", rf_wdata, 32'h11);
    compare_model();
    advance();
    drive_idle(1'b1);
    settle();
    check_eq("skid_second_addr", rf_waddr, 32'd6);
    check_eq("skid_second_data", rf_wdata, 32'h22);
    compare_model();
    advance();
    settle();
    check_eq("skid_retired", retired_count, base_count + 32'd2);
    compare_model();
    advance();

    // Zero register retires without grant.
    base_count = exp_count;
    drive(1'b1, 2'b01, 5'd0, 32'h55, 32'd0, 2'b10, 1'b0, 2'd0, 1'b0);
    step();
    drive_idle(1'b0);
    settle();
    check_eq("zero_reg_no_we", rf_we, 1'b0);
    compare_model();
    advance();
    settle();
    check_eq("zero_reg_retired", retired_count, base_count + 32'd1);
    compare_model();
    advance();

    // Forwarding priority: skid over head.
    drive(1'b1, 2'b01, 5'd7, 32'hA, 32'd0, 2'b10, 1'b0, 2'd0, 1'b0);
    step();
    drive(1'b1, 2'b01, 5'd7, 32'hB, 32'd0, 2'b10, 1'b0, 2'd0, 1'b0);
    step();
    drive_idle(1'b0);
    settle();
    check_eq("fwd_prio_valid", fwd_valid, 1'b1);
    check_eq("fwd_prio_addr", fwd_addr, 32'd7);
    check_eq("fwd_prio_data", fwd_data, 32'hB);
    compare_model();
    advance();
    drive_idle(1'b1);
    step();
    step();

    // Misaligned half load.
    drive(1'b1, 2'b11, 5'd8, 32'd0, 32'h1234_ABCD, 2'b01, 1'b1, 2'd1, 1'b1);
    step();
    drive_idle(1'b1);
    settle();
    check_eq("misalign_pulse", align_err, 1'b1);
    check_eq("misalign_data", rf_wdata, 32'h0000_ABCD);
    compare_model();
    advance();
    settle();
    check_eq("misalign_one_cycle", align_err, 1'b0);
    compare_model();
    advance();

    // Reset mid-stall.
    drive(1'b1, 2'b01, 5'd10, 32'h77, 32'd0, 2'b10, 1'b0, 2'd0, 1'b0);
    step();
    drive(1'b1, 2'b01, 5'd11, 32'h88, 32'd0, 2'b10, 1'b0, 2'd0, 1'b0);
    step();
    drive_idle(1'b1);
    rst = 1'b1;
    #1;
    check_eq("rst_rf_we", rf_we, 1'b0);
    check_eq("rst_fwd_valid", fwd_valid, 1'b0);
    check_eq("rst_retired", retired_count, 32'd0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("post_rst_no_write", rf_we, 1'b0);
      compare_model();
      advance();
    end

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) < 70, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
            $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), $urandom_range(0, 99) < 60);
      step();
    end
    drive_idle(1'b1);
    step();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
